// File: rtl/pin_console_tx_pkg.sv
// rtl/pin_console_tx_pkg.sv - lane map and handshake state shared by the console source, sink and firmware
package pin_console_tx_pkg;

  localparam int PIN_AVAIL   = 0;
  localparam int PIN_END     = 1;
  localparam int PIN_DATA_LO = 2;
  localparam int PIN_DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } hs_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with occupancy count and combinational head
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pin_console_tx.sv
// rtl/pin_console_tx.sv - queues host bytes and presents them on cpu pin_in with an avail/ack four-phase handshake
module pin_console_tx
  import pin_console_tx_pkg::*;
#(
  parameter int BITNESS = 16,
  parameter int DEPTH   = 8,
  parameter int ACK_PIN = 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               h_valid,
  input  logic [7:0]         h_data,
  output logic               h_ready,
  input  logic               h_eof,
  input  logic [BITNESS-1:0] pin_out,
  output logic [BITNESS-1:0] pin_in,
  output logic [LW-1:0]      level
);

  hs_state_t  state;
  hs_state_t  state_nxt;
  logic [7:0] data_q;
  logic [7:0] head;
  logic       ack;
  logic       push;
  logic       pop;
  logic       load;
  logic       unused_pins;

  assign ack         = pin_out[ACK_PIN];
  assign unused_pins = ^pin_out;
  assign h_ready     = (level != LW'(DEPTH));
  assign push        = h_valid && h_ready;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push),
    .push_data(h_data),
    .pop      (pop),
    .head     (head),
    .level    (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (level != '0) state_nxt = ST_PRESENT;
      ST_PRESENT: if (ack)         state_nxt = ST_RELEASE;
      ST_RELEASE: if (!ack)        state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // IDLE only looks at occupancy, so a stray ack there is harmless.
  always_comb begin
    load = 1'b0;
    pop  = 1'b0;
    case (state)
      ST_IDLE:    load = (level != '0);
      ST_PRESENT: pop  = ack;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= head;
    end else if (pop) begin
      data_q <= '0;
    end
  end

  // END falls in the same cycle as a push so the CPU never sees END while a byte is on its way.
  always_comb begin
    pin_in                                = '0;
    pin_in[PIN_AVAIL]                     = (state == ST_PRESENT);
    pin_in[PIN_END]                       = rst && h_eof && (level == '0) &&
                                            (state == ST_IDLE) && !push;
    pin_in[PIN_DATA_LO +: PIN_DATA_W]     = data_q;
  end

endmodule

// File: tb/tb_pin_console_tx.sv
// tb/tb_pin_console_tx.sv - scoreboard bench for pin_console_tx with directed and randomized traffic
module tb_pin_console_tx;

  localparam int BITNESS = 16;
  localparam int DEPTH   = 8;
  localparam int ACK_PIN = 1;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               h_valid = 1'b0;
  logic [7:0]         h_data = 8'h00;
  logic               h_ready;
  logic               h_eof = 1'b0;
  logic               ack = 1'b0;
  logic [BITNESS-1:0] noise = '0;
  logic [BITNESS-1:0] pin_out;
  logic [BITNESS-1:0] pin_in;
  logic [LW-1:0]      level;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int         mlevel     = 0;
  logic       prev_avail = 1'b0;
  logic [7:0] cur_byte   = 8'h00;

  assign pin_out = (noise & ~(BITNESS'(1) << ACK_PIN)) | (BITNESS'(ack) << ACK_PIN);

  pin_console_tx #(
    .BITNESS(BITNESS),
    .DEPTH  (DEPTH),
    .ACK_PIN(ACK_PIN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .h_valid(h_valid),
    .h_data (h_data),
    .h_ready(h_ready),
    .h_eof  (h_eof),
    .pin_out(pin_out),
    .pin_in (pin_in),
    .level  (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_avail(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = pin_in[0];
    end
    check("avail_wait", seen, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      wait_avail(20);
      tick(1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
    end
  endtask

  // Reference: FIFO of bytes in push order; each presentation consumes the oldest byte.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      mlevel     = 0;
      prev_avail = 1'b0;
    end else begin
      check("level", level, mlevel);
      check("h_ready", h_ready, mlevel != DEPTH);
      check("upper_lanes", pin_in[BITNESS-1:10], 0);
      check("avail_end_both", pin_in[0] && pin_in[1], 0);
      if (!h_eof) check("end_without_eof", pin_in[1], 0);
      if (pin_in[0]) begin
        if (!prev_avail) begin
          check("present_queue_empty", exp_q.size() == 0, 0);
          if (exp_q.size() != 0) cur_byte = exp_q.pop_front();
        end
        check("present_byte", pin_in[9:2], cur_byte);
      end else begin
        check("idle_data_lanes", pin_in[9:2], 0);
      end
      prev_avail = pin_in[0];
      if (h_valid && mlevel != DEPTH) begin
        exp_q.push_back(h_data);
        mlevel++;
      end
      if (ack && pin_in[0]) mlevel--;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset hold with a pending write
    h_valid = 1'b1;
    h_data  = 8'h41;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pin_in", pin_in, 0);
    check("rst_level", level, 0);
    check("rst_h_ready", h_ready, 1);
    tick(1);
    rst = 1'b1;
    h_valid = 1'b0;
    tick(3);
    @(negedge clk);
    check("no_push_avail", pin_in[0], 0);

    // single byte: AVAIL in the second cycle after the push edge
    tick(1);
    h_valid = 1'b1;
    h_data  = 8'h48;
    tick(1);
    h_valid = 1'b0;
    @(negedge clk);
    check("avail_early", pin_in[0], 0);
    check("single_level", level, 1);
    tick(1);
    @(negedge clk);
    check("avail_latency", pin_in[0], 1);
    check("h48_lanes", pin_in[9:2], 8'h48);
    check("h48_lane5", pin_in[5], 1);
    check("h48_lane8", pin_in[8], 1);
    tick(1);
    ack = 1'b1;
    tick(1);
    @(negedge clk);
    check("release_avail", pin_in[0], 0);
    check("single_pop_level", level, 0);
    tick(1);
    ack = 1'b0;
    tick(2);
    @(negedge clk);
    check("single_done_level", level, 0);

    // full FIFO with a ninth byte held off
    tick(1);
    for (int k = 0; k < 8; k++) begin
      h_valid = 1'b1;
      h_data  = 8'(8'h30 + k);
      tick(1);
    end
    h_data = 8'h38;
    @(negedge clk);
    check("full_h_ready", h_ready, 0);
    check("full_level", level, DEPTH);
    check("full_head", pin_in[9:2], 8'h30);
    tick(2);
    @(negedge clk);
    check("full_held_level", level, DEPTH);
    tick(1);
    ack = 1'b1;
    tick(1);
    @(negedge clk);
    check("after_pop_level", level, DEPTH - 1);
    check("after_pop_ready", h_ready, 1);
    tick(1);
    h_valid = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    check("refill_level", level, DEPTH);
    drain(8);

    // ack held high across the release phase
    tick(3);
    h_valid = 1'b1;
    h_data  = 8'h61;
    tick(1);
    h_data  = 8'h62;
    tick(1);
    h_valid = 1'b0;
    wait_avail(10);
    check("held_first", pin_in[9:2], 8'h61);
    tick(1);
    ack = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("held_avail", pin_in[0], 0);
      check("held_level", level, 1);
      tick(1);
    end
    ack = 1'b0;
    wait_avail(10);
    check("held_second", pin_in[9:2], 8'h62);
    drain(1);

    // push and pop on the same edge
    tick(3);
    for (int k = 0; k < 3; k++) begin
      h_valid = 1'b1;
      h_data  = 8'(8'h70 + k);
      tick(1);
    end
    h_valid = 1'b0;
    wait_avail(10);
    check("pp_level_before", level, 3);
    tick(1);
    ack = 1'b1;
    h_valid = 1'b1;
    h_data = 8'h73;
    tick(1);
    h_valid = 1'b0;
    ack = 1'b0;
    @(negedge clk);
    check("pp_level_after", level, 3);
    drain(3);

    // END lane and its combinational drop on push
    tick(3);
    h_eof = 1'b1;
    tick(2);
    @(negedge clk);
    check("end_lane", pin_in[1], 1);
    check("end_avail", pin_in[0], 0);
    tick(1);
    h_valid = 1'b1;
    h_data = 8'h0A;
    #1;
    check("end_push_drop", pin_in[1], 0);
    tick(1);
    h_valid = 1'b0;
    wait_avail(10);
    check("end_byte", pin_in[9:2], 8'h0A);
    drain(1);
    tick(1);
    h_eof = 1'b0;

    // asynchronous reset while presenting
    tick(3);
    for (int k = 0; k < 4; k++) begin
      h_valid = 1'b1;
      h_data  = 8'(8'h80 + k);
      tick(1);
    end
    h_valid = 1'b0;
    wait_avail(10);
    check("pre_rst_level", level, 4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_lanes", pin_in, 0);
    check("async_rst_level", level, 0);
    tick(1);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_avail", pin_in[0], 0);

    // randomized traffic with a sluggish CPU and noise on unused pin_out lanes
    tick(1);
    fork
      begin
        logic acc;
        for (int i = 0; i < 40; i++) begin
          h_valid = 1'b1;
          h_data  = 8'($urandom);
          acc = 1'b0;
          for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = h_ready;
            tick(1);
          end
          check("push_timeout", acc, 1);
          h_valid = 1'b0;
          tick($urandom_range(0, 3));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          wait_avail(400);
          @(posedge clk);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          ack = 1'b1;
          @(posedge clk);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          ack = 1'b0;
          noise = BITNESS'($urandom);
        end
      end
    join
    tick(6);
    @(negedge clk);
    check("final_level", level, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
